// File: rtl/fp_pkg.sv
// Shared types, constants and the Q16.16 -> float32 conversion for fp_cvt_arbiter.
// Latency: n/a (package; the conversion function is purely combinational).
// Backpressure: n/a.
package fp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      OUT  = 2'd2
   } cvt_state_t;

   localparam int          F32_BIAS      = 127;
   localparam int          Q16_INT_MSB   = 15;
   localparam logic [31:0] F32_POS_ZERO  = 32'h0000_0000;
   localparam logic [31:0] F32_NEG_32768 = 32'hC700_0000;

   // Sign-magnitude split, normalise on the leading one, truncate the mantissa.
   // A zero magnitude yields lzc=32 and therefore exponent 110 with a zero mantissa.
   function automatic logic [31:0] q16_to_f32(input logic [31:0] q);
      logic [31:0] mag;
      logic [31:0] norm;
      logic [5:0]  lzc;
      logic        found;
      logic [7:0]  exp_v;
      mag   = q[31] ? (~q + 32'd1) : q;
      lzc   = 6'd32;
      found = 1'b0;
      for (int i = 31; i >= 0; i--) begin
         if (!found && mag[i]) begin
            lzc   = 6'(31 - i);
            found = 1'b1;
         end
      end
      norm  = mag << lzc;
      exp_v = 8'(F32_BIAS + Q16_INT_MSB - int'(lzc));
      return {q[31], exp_v, norm[30:8]};
   endfunction

endpackage

// File: rtl/fp_cvt_arbiter_rr_arbiter.sv
// Round-robin grant selection starting one past the last granted requester.
// Latency: combinational.
// Backpressure: none; en low forces an all-zero grant.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int SRC_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [SRC_W-1:0]   last_grant,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [SRC_W-1:0]   grant_idx
);

   // Walk the requesters from last_grant+1 with wrap; first valid one wins.
   always_comb begin
      logic             found;
      logic [SRC_W-1:0] idx;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = SRC_W'((int'(last_grant) + i) % NUM_REQ);
         if (en && !found && req_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/fp_cvt_arbiter.sv
// Shares one Q16.16->float32 converter among NUM_REQ requesters (round-robin); optional FP_CVT_ZERO_FIX_EN.
// Latency: accept at cycle T gives out_valid from T+2; one result per 3 cycles at best.
// Backpressure: out_ready low holds the result in OUT and keeps every req_ready low.
module fp_cvt_arbiter
   import fp_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int SRC_W   = $clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ-1:0][31:0] req_data,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_data,
   output logic [SRC_W-1:0]        out_src,
   output logic [31:0]             conv_count
);

   cvt_state_t         state;
   cvt_state_t         state_nxt;
   logic [31:0]        op_q;
   logic [SRC_W-1:0]   src_q;
   logic [SRC_W-1:0]   last_grant;
   logic [NUM_REQ-1:0] grant;
   logic [SRC_W-1:0]   grant_idx;
   logic               arb_en;
   logic               accept;
   logic               fire;
   logic [31:0]        cvt_res;
   logic [31:0]        cvt_sel;

   // Grants are only offered in IDLE and never while reset is asserted.
   assign arb_en = (state == IDLE) && !rst;
   assign accept = |grant;
   assign fire   = out_valid && out_ready;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .SRC_W   (SRC_W)
   ) u_rr_arbiter (
      .req_valid  (req_valid),
      .last_grant (last_grant),
      .en         (arb_en),
      .grant      (grant),
      .grant_idx  (grant_idx)
   );

   assign cvt_res = q16_to_f32(op_q);

`ifdef FP_CVT_ZERO_FIX_EN
   // Zero would otherwise come out as 2^-17; the most-negative operand is pinned explicitly.
   always_comb begin
      cvt_sel = cvt_res;
      if (op_q == 32'h0000_0000)
         cvt_sel = F32_POS_ZERO;
      else if (op_q == 32'h8000_0000)
         cvt_sel = F32_NEG_32768;
   end
`else
   assign cvt_sel = cvt_res;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic: IDLE -> CONV on accept, CONV -> OUT, OUT -> IDLE on handshake.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = CONV;
         CONV:    state_nxt = OUT;
         OUT:     if (fire) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: grant straight through, valid while holding a result.
   always_comb begin
      req_ready = grant;
      out_valid = (state == OUT);
   end

   // Operand capture, result register and saturating handshake counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q       <= '0;
         src_q      <= '0;
         last_grant <= SRC_W'(NUM_REQ - 1);
         out_data   <= '0;
         out_src    <= '0;
         conv_count <= '0;
      end else begin
         if (accept) begin
            op_q       <= req_data[grant_idx];
            src_q      <= grant_idx;
            last_grant <= grant_idx;
         end
         if (state == CONV) begin
            out_data <= cvt_sel;
            out_src  <= src_q;
         end
         if (fire && (conv_count != 32'hFFFF_FFFF))
            conv_count <= conv_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_fp_cvt_arbiter.sv
// Directed bench for fp_cvt_arbiter with a reference converter and a result scoreboard.
// Latency: checks accept-to-valid distance of two cycles.
// Backpressure: exercises out_ready held low in OUT.
module tb_fp_cvt_arbiter;

   localparam int NUM_REQ = 4;
   localparam int SRC_W   = 2;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0][31:0]  req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      out_valid;
   logic                      out_ready;
   logic [31:0]               out_data;
   logic [SRC_W-1:0]          out_src;
   logic [31:0]               conv_count;

   int          errors = 0;
   int          checks = 0;
   int          lg     = NUM_REQ - 1;
   logic [31:0] exp_cnt = 32'd0;
   logic [31:0] sb_data[$];
   int          sb_src[$];

   fp_cvt_arbiter #(.NUM_REQ(NUM_REQ)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_src    (out_src),
      .conv_count (conv_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // Reference: locate the most significant set bit of the magnitude directly.
   function automatic logic [31:0] ref_cvt(input logic [31:0] q);
      logic [31:0] mag;
      logic [31:0] norm;
      logic [7:0]  e;
      int          p;
      mag = q[31] ? (~q + 32'd1) : q;
      p   = -1;
      for (int i = 0; i < 32; i++)
         if (mag[i]) p = i;
      if (p < 0) begin
         e    = 8'd110;
         norm = 32'd0;
      end else begin
         e    = 8'(111 + p);
         norm = mag << (31 - p);
      end
`ifdef FP_CVT_ZERO_FIX_EN
      if (q == 32'd0) return 32'd0;
`endif
      return {q[31], e, norm[30:8]};
   endfunction

   // One full transaction: offer vmask in IDLE, follow it through CONV/OUT, hold out_ready low 'hold' cycles.
   task automatic serve(input logic [NUM_REQ-1:0] vmask, input int hold);
      int          g;
      int          n;
      logic [31:0] ed;
      int          es;
      logic [NUM_REQ-1:0] oh;
      @(negedge clk);
      req_valid = vmask;
      out_ready = (hold == 0);
      #1;
      chk("conv_count", conv_count, exp_cnt);
      g = -1;
      for (int i = 1; i <= NUM_REQ; i++)
         if (g < 0 && vmask[(lg + i) % NUM_REQ]) g = (lg + i) % NUM_REQ;
      oh = '0;
      if (g >= 0) oh[g] = 1'b1;
      chk("req_ready_grant", 32'(req_ready), 32'(oh));
      if (g >= 0) begin
         sb_data.push_back(ref_cvt(req_data[g]));
         sb_src.push_back(g);
         lg = g;
      end
      n = 0;
      while (n < 4) begin
         @(negedge clk);
         #1;
         n++;
         if (out_valid) break;
         chk("req_ready_conv", 32'(req_ready), 32'd0);
      end
      chk("latency", 32'(n), 32'd2);
      if (sb_data.size() == 0) begin
         chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
         ed = sb_data.pop_front();
         es = sb_src.pop_front();
         chk("out_data", out_data, ed);
         chk("out_src", 32'(out_src), 32'(es));
         for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", out_data, ed);
            chk("hold_src", 32'(out_src), 32'(es));
            chk("hold_ready", 32'(req_ready), 32'd0);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '1;
      req_data  = '0;
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_src", 32'(out_src), 32'd0);
      chk("rst_conv_count", conv_count, 32'd0);
      @(negedge clk);
      rst       = 1'b0;
      req_valid = '0;

      // Single requests covering positive, negative, fractional, zero and most-negative.
      req_data[0] = 32'h0001_0000; serve(4'b0001, 0);
      req_data[1] = 32'hFFFF_0000; serve(4'b0010, 0);
      req_data[2] = 32'h0001_8000; serve(4'b0100, 0);
      req_data[3] = 32'h0000_0000; serve(4'b1000, 0);
      req_data[0] = 32'h8000_0000; serve(4'b0001, 0);
      chk("known_1p0", ref_cvt(32'h0001_0000), 32'h3F80_0000);

      // Reset while in CONV: operand discarded, counter cleared, priority back to 0.
      @(negedge clk);
      req_valid   = 4'b0001;
      req_data[0] = 32'h0002_0000;
      #1;
      chk("rstconv_grant", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rstconv_valid_conv", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst       = 1'b0;
      req_valid = '0;
      lg        = NUM_REQ - 1;
      exp_cnt   = 32'd0;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("rstconv_no_valid", 32'(out_valid), 32'd0);
         chk("rstconv_count", conv_count, 32'd0);
         @(negedge clk);
      end

      // Fairness with all requesters continuously valid: expect 0,1,2,3,0.
      req_data[0] = 32'h0003_0000;
      req_data[1] = 32'hFFFE_8000;
      req_data[2] = 32'h7FFF_FFFF;
      req_data[3] = 32'h0000_0001;
      for (int r = 0; r < 5; r++) serve(4'b1111, 0);

      // Same requester alone is re-granted; a competing one wins next.
      serve(4'b0001, 0);
      serve(4'b0011, 0);

      // Backpressure: five cycles of out_ready low in OUT.
      serve(4'b0110, 5);
      serve(4'b0110, 0);

      // Reset in the same cycle as a request: no grant.
      @(negedge clk);
      rst       = 1'b1;
      req_valid = 4'b1111;
      #1;
      chk("rst_req_same_cycle", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst       = 1'b0;
      req_valid = '0;
      lg        = NUM_REQ - 1;
      exp_cnt   = 32'd0;
      #1;
      chk("rst_req_out_valid", 32'(out_valid), 32'd0);
      serve(4'b1010, 0);

      // Saturation of the handshake counter.
      @(negedge clk);
      req_valid = '0;
      force dut.conv_count = 32'hFFFF_FFFF;
      release dut.conv_count;
      exp_cnt = 32'hFFFF_FFFF;
      serve(4'b0001, 0);
      @(negedge clk);
      req_valid = '0;
      #1;
      chk("conv_count_sat", conv_count, 32'hFFFF_FFFF);
      chk("sb_drained", 32'(sb_data.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fp_cvt_arbiter.md
# fp_cvt_arbiter

Round-robin arbiter and sequencer that shares one combinational Q16.16-to-float32 conversion datapath among `NUM_REQ` requesters. Each requester offers a signed Q16.16 operand over a valid/ready handshake. The block grants one requester, registers the operand, converts it, and presents the float32 result with the source index on a single valid/ready output port. It sits between the integer/fixed-point producers and the FPU result bus.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `SRC_W`, `$clog2(NUM_REQ)`: width of the source index (derived; do not override).
- `clk`  in  1: clock; all logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  `NUM_REQ`: per-requester operand valid.
- `req_data`  in  `NUM_REQ`×32: per-requester signed Q16.16 operand.
- `req_ready`  out  `NUM_REQ`: one-hot grant/accept; at most one bit high.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: consumer accepts the result.
- `out_data`  out  32: IEEE-754 float32 result.
- `out_src`  out  `SRC_W`: index of the requester that produced `out_data`.
- `conv_count`  out  32: number of completed output handshakes; saturates at 0xFFFFFFFF.

## Operation
- FSM states:
  - IDLE: wait for a request.
  - CONV: convert the captured operand.
  - OUT: hold the result until it is consumed.
- Reset state is IDLE.
- IDLE:
  - If any `req_valid` is high, assert `req_ready[g]` combinationally for the granted index g, in the same cycle.
  - On that edge, capture `req_data[g]` into the operand register and g into the source register, update `last_grant` to g, and go to CONV.
- Round-robin search starts at `(last_grant+1) mod NUM_REQ` and wraps. `last_grant` resets to `NUM_REQ-1`, so requester 0 has first priority.
- `req_ready` is all-zero in CONV and OUT, and all-zero in IDLE when no `req_valid` is high.
- CONV: feed the operand register to the conversion datapath, register the result into `out_data` and the source into `out_src`, then go to OUT.
- OUT:
  - `out_valid`=1.
  - On `out_valid && out_ready`, increment `conv_count` (saturating) and go to IDLE.
  - `out_data` and `out_src` stay stable while `out_valid`=1 and `out_ready`=0.
- Conversion rules:
  - Sign bit = operand[31].
  - Magnitude = two's complement of the operand when it is negative.
  - Exponent = 127 + 15 − (leading-zero count of the magnitude).
  - Mantissa = the 23 bits following the leading one, truncated (no rounding).
- A requester dropping `req_valid` before it is granted is legal and is not recorded.
- A granted requester's `req_data` is sampled only in its grant cycle.

## Timing
- Reset values (all outputs): `req_ready`=0, `out_valid`=0, `out_data`=0, `out_src`=0, `conv_count`=0; state = IDLE; `last_grant`=`NUM_REQ-1`.
- Latency: an accept edge at cycle T gives `out_valid`=1 from cycle T+2.
- Throughput: with `out_ready` tied high, one result every 3 cycles (IDLE, CONV, OUT).
- Back-to-back requests from the same requester: the requester is granted again only when no other requester is valid in that IDLE cycle.
- Reset mid-operation: `rst` in CONV or OUT discards the operand and result. `out_valid` is 0 on the next cycle, the FSM is in IDLE, and `conv_count` is cleared.
- `rst` in the same cycle as a request: no accept occurs and `req_ready` is forced 0.
- `conv_count` at 0xFFFFFFFF stays at 0xFFFFFFFF on further handshakes.

## Configuration
- `FP_CVT_ZERO_FIX_EN`, when defined:
  - An operand of 0x00000000 produces `out_data`=0x00000000 (+0.0).
  - An operand of 0x80000000 produces 0xC7000000 (−32768.0).
  - These outputs bypass the datapath result in CONV. All other operands are unchanged.
- When undefined: `out_data` is the raw datapath result for every operand, zero and most-negative included; no bypass logic is synthesized.

## Structure
- Shared package `fp_pkg`:
  - FSM state enum `cvt_state_t` (IDLE, CONV, OUT).
  - Constants `F32_BIAS`=127, `Q16_INT_MSB`=15, `F32_POS_ZERO`=32'h0, `F32_NEG_32768`=32'hC7000000.
- One sub-module, `rr_arbiter`:
  - Parameterized by `NUM_REQ`.
  - Inputs: `req_valid`, `last_grant`, enable.
  - Outputs: one-hot grant and its binary index. Purely combinational.
- The conversion datapath is instantiated unchanged inside the CONV register stage.

## Test plan
- Single request: requester 0 sends 0x00010000 → accept at T, then `out_valid` at T+2 with `out_data`=0x3F800000, `out_src`=0, and `conv_count`=1 after the handshake.
- Negative and fractional operands: 0xFFFF0000 → 0xBF800000; 0x00018000 → 0x3FC00000; 0x00000000 with `FP_CVT_ZERO_FIX_EN` → 0x00000000.
- Fairness: all 4 requesters valid continuously → grant order 0,1,2,3,0 and exactly one `req_ready` bit high per accept.
- Backpressure: `out_ready`=0 for 5 cycles in OUT → `out_data` and `out_src` stable, no new `req_ready`, accept resumes in the IDLE cycle after the handshake.
- Reset in CONV: accept 0x00020000, assert `rst` next cycle → `out_valid` never asserts for it, `conv_count`=0, and requester 0 is granted first afterwards.
- Saturation: force `conv_count` to 0xFFFFFFFF, complete one more handshake → `conv_count` stays 0xFFFFFFFF.
